// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Holds the geometry constants, the FSM state encoding, the address split
// helpers ({tag, index}) and the saturating counter increment.
package cache_pkg;

    localparam int INDEX_W   = 10;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = TAG_W + INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_UPDATE    = 3'd4
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/cache_line_status.sv
// Per-line valid/dirty state for the direct-mapped cache.
// Ports:
//   globalclock, reset      - clock, synchronous active-high reset (clears all lines)
//   rd_idx -> rd_valid/rd_dirty - combinational read of one line
//   wr_en, wr_idx, wr_valid, wr_dirty - single write port, lands on the rising edge
module cache_line_status
    import cache_pkg::*;
(
    input  logic               globalclock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_valid,
    input  logic               wr_dirty
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            dirty_d[wr_idx] = wr_dirty;
        end
    end

    always_ff @(posedge globalclock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/direct_cache_controller.sv
// Sequencing FSM for a direct-mapped, write-back / write-allocate cache with
// one data word per line. Serves one CPU load/store at a time, drives the
// external tag and data memories and runs write-back / fill transactions on RAM.
// Ports:
//   globalclock, reset                         - clock, synchronous active-high reset
//   cpu_req/cpu_rw/cpu_addr/cpu_wdata          - CPU request, accepted only while cpu_ready
//   cpu_ready/cpu_done/cpu_rdata               - idle flag, completion pulse, load data
//   tag_wr_en/tag_addr/tag_in, tag_out         - tag memory write port and comb read
//   data_wr_en/data_addr/data_in, data_out     - data memory port and comb read
//   ram_req/ram_we/ram_addr/ram_wdata          - RAM request, held until ram_ack
//   ram_ack/ram_rdata                          - RAM completion and fill data
//   hit_count/miss_count                       - saturating event counters
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a CPU request
// COMPARE    | tag/valid lookup; hits complete here
// WRITEBACK  | dirty victim being written to RAM
// ALLOCATE   | requested line being fetched from RAM
// UPDATE     | tag/data/line state written, request completes
module direct_cache_controller
    import cache_pkg::*;
(
    input  logic               globalclock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_rw,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ready,
    output logic               cpu_done,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               tag_wr_en,
    output logic [INDEX_W-1:0] tag_addr,
    output logic [TAG_W-1:0]   tag_in,
    input  logic [TAG_W-1:0]   tag_out,
    output logic               data_wr_en,
    output logic [INDEX_W-1:0] data_addr,
    output logic [DATA_W-1:0]  data_in,
    input  logic [DATA_W-1:0]  data_out,
    output logic               ram_req,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic               ram_ack,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic [DATA_W-1:0]  victim_data_q, victim_data_d;
    logic [DATA_W-1:0]  fill_q, fill_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic               cpu_done_q, cpu_done_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] lat_idx;
    logic               line_valid, line_dirty;
    logic               hit;
    logic               st_wr_en;

    assign lat_tag = addr_tag(addr_q);
    assign lat_idx = addr_index(addr_q);
    assign hit     = line_valid && (tag_out == lat_tag);

    cache_line_status u_status (
        .globalclock (globalclock),
        .reset       (reset),
        .rd_idx      (lat_idx),
        .rd_valid    (line_valid),
        .rd_dirty    (line_dirty),
        .wr_en       (st_wr_en),
        .wr_idx      (lat_idx),
        .wr_valid    (1'b1),
        .wr_dirty    (rw_q)
    );

    // State register
    always_ff @(posedge globalclock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (hit)                          state_d = ST_IDLE;
                else if (line_valid && line_dirty) state_d = ST_WRITEBACK;
                else                              state_d = ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                if (ram_ack) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                if (ram_ack) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. The write-hit data/line-state write in COMPARE necessarily
    // depends on the tag compare; everything else is purely state + latches.
    always_comb begin
        cpu_ready  = (state_q == ST_IDLE);
        tag_addr   = lat_idx;
        data_addr  = lat_idx;
        tag_wr_en  = (state_q == ST_UPDATE);
        tag_in     = lat_tag;
        data_wr_en = 1'b0;
        data_in    = wdata_q;
        st_wr_en   = 1'b0;
        ram_req    = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = victim_data_q;
        case (state_q)
            ST_COMPARE: begin
                data_wr_en = hit && rw_q;
                st_wr_en   = hit && rw_q;
            end
            ST_WRITEBACK: begin
                ram_req  = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {victim_tag_q, lat_idx};
            end
            ST_ALLOCATE: begin
                ram_req = 1'b1;
            end
            ST_UPDATE: begin
                data_wr_en = 1'b1;
                st_wr_en   = 1'b1;
                data_in    = rw_q ? wdata_q : fill_q;
            end
            default: ;
        endcase
    end

    // Request latches, victim capture, fill capture, CPU response, counters
    always_comb begin
        addr_d        = addr_q;
        rw_d          = rw_q;
        wdata_d       = wdata_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;
        fill_d        = fill_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_done_d    = 1'b0;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    rw_d    = cpu_rw;
                    wdata_d = cpu_wdata;
                end
            end
            ST_COMPARE: begin
                if (hit) begin
                    cpu_done_d  = 1'b1;
                    hit_count_d = sat_inc(hit_count_q);
                    if (!rw_q) cpu_rdata_d = data_out;
                end else begin
                    miss_count_d  = sat_inc(miss_count_q);
                    victim_tag_d  = tag_out;
                    victim_data_d = data_out;
                end
            end
            ST_ALLOCATE: begin
                if (ram_ack) fill_d = ram_rdata;
            end
            ST_UPDATE: begin
                cpu_done_d = 1'b1;
                if (!rw_q) cpu_rdata_d = fill_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge globalclock) begin
        if (reset) begin
            addr_q        <= '0;
            rw_q          <= 1'b0;
            wdata_q       <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            fill_q        <= '0;
            cpu_rdata_q   <= '0;
            cpu_done_q    <= 1'b0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            wdata_q       <= wdata_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            fill_q        <= fill_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_done_q    <= cpu_done_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign cpu_done   = cpu_done_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_direct_cache_controller.sv
module tb_direct_cache_controller;
    import cache_pkg::*;

    logic               globalclock = 1'b0;
    logic               reset;
    logic               cpu_req, cpu_rw;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_ready, cpu_done;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               tag_wr_en;
    logic [INDEX_W-1:0] tag_addr;
    logic [TAG_W-1:0]   tag_in, tag_out;
    logic               data_wr_en;
    logic [INDEX_W-1:0] data_addr;
    logic [DATA_W-1:0]  data_in, data_out;
    logic               ram_req, ram_we, ram_ack;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata, ram_rdata;
    logic [CNT_W-1:0]   hit_count, miss_count;

    always #5 globalclock = ~globalclock;

    direct_cache_controller dut (
        .globalclock (globalclock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .tag_wr_en   (tag_wr_en),
        .tag_addr    (tag_addr),
        .tag_in      (tag_in),
        .tag_out     (tag_out),
        .data_wr_en  (data_wr_en),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_ack     (ram_ack),
        .ram_rdata   (ram_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // External tag/data memories: combinational read, write on rising edge.
    logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
    logic [DATA_W-1:0] data_mem [NUM_LINES];
    logic              mem_init;

    assign tag_out  = tag_mem[tag_addr];
    assign data_out = data_mem[data_addr];

    always @(posedge globalclock) begin
        if (mem_init) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_mem[i]  <= 3'd2;
                data_mem[i] <= 8'h00;
            end
        end else begin
            if (tag_wr_en)  tag_mem[tag_addr]   <= tag_in;
            if (data_wr_en) data_mem[data_addr] <= data_in;
        end
    end

    logic [DATA_W-1:0] ram_mem [1 << ADDR_W];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_exp_t;

    typedef struct {
        bit                is_read;
        logic [DATA_W-1:0] rdata;
    } cpu_exp_t;

    ram_exp_t ram_q[$];
    cpu_exp_t cpu_q[$];

    int n_cmp;
    int n_fail;
    int ack_delay;
    int ram_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM responder + RAM-side scoreboard. Acks after ack_delay waiting
    // cycles; each ack is checked against the next expected transaction.
    task automatic ram_responder();
        ram_exp_t e;
        forever begin
            @(negedge globalclock);
            if (ram_req) begin
                if (ram_cnt >= ack_delay) begin
                    ram_ack = 1'b1;
                    ram_cnt = 0;
                    n_cmp++;
                    if (ram_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ram_unexpected: got we=%0b addr=%0h wdata=%0h, expected no request",
                                 ram_we, ram_addr, ram_wdata);
                    end else begin
                        e = ram_q.pop_front();
                        if (ram_we !== e.we || ram_addr !== e.addr || (e.we && ram_wdata !== e.wdata)) begin
                            n_fail++;
                            $display("FAIL ram_txn: got we=%0b addr=%0h wdata=%0h expected we=%0b addr=%0h wdata=%0h",
                                     ram_we, ram_addr, ram_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                    else        ram_rdata = ram_mem[ram_addr];
                end else begin
                    ram_ack = 1'b0;
                    ram_cnt++;
                end
            end else begin
                ram_ack = 1'b0;
                ram_cnt = 0;
            end
        end
    endtask

    // CPU-side monitor: pops an expectation on every cpu_done.
    task automatic cpu_monitor();
        cpu_exp_t e;
        forever begin
            @(negedge globalclock);
            if (cpu_done) begin
                n_cmp++;
                if (cpu_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cpu_unexpected_done: got cpu_done=1 rdata=%0h, expected no completion", cpu_rdata);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_read && cpu_rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL cpu_rdata: got %0h expected %0h", cpu_rdata, e.rdata);
                    end
                end
            end
        end
    endtask

    task automatic push_ram(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        ram_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd;
        ram_q.push_back(e);
    endtask

    // Issue one request; check completion latency in cycles after acceptance.
    task automatic do_req(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                          input logic [DATA_W-1:0] exp_rdata, input int exp_lat, input string name);
        cpu_exp_t e;
        int  cyc;
        bit  done;
        e.is_read = !rw; e.rdata = exp_rdata;
        cpu_q.push_back(e);
        @(negedge globalclock);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        @(posedge globalclock);
        #1 cpu_req = 1'b0;
        cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge globalclock);
            cyc++;
            if (cpu_done) done = 1;
        end
        chk({name, "_latency"}, done ? cyc : 32'hDEAD, exp_lat);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ram_ack = 1'b0; ram_rdata = '0;
        ack_delay = 1; ram_cnt = 0; n_cmp = 0; n_fail = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = '0;
        ram_mem[13'h0005] = 8'hA5;
        ram_mem[13'h0405] = 8'h77;
        ram_mem[13'h1FFF] = 8'h11;
        ram_mem[13'h0FFF] = 8'h22;

        fork
            ram_responder();
            cpu_monitor();
        join_none

        repeat (3) @(posedge globalclock);
        @(negedge globalclock);
        mem_init = 1'b0;
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_wr_en", {tag_wr_en, data_wr_en}, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        reset = 1'b0;

        // Read miss after reset, fill A5, tag 0 written.
        ack_delay = 1;
        push_ram(1'b0, 13'h0005, 8'h00);
        do_req(1'b0, 13'h0005, 8'h00, 8'hA5, 5, "rd_miss_5");
        chk("miss_count_1", miss_count, 1);
        chk("tag_5_after_fill", tag_mem[5], 0);

        // Repeat read hits.
        do_req(1'b0, 13'h0005, 8'h00, 8'hA5, 2, "rd_hit_5");
        chk("hit_count_1", hit_count, 1);

        // Write hit makes line 5 dirty.
        do_req(1'b1, 13'h0005, 8'h5A, 8'h00, 2, "wr_hit_5");
        chk("hit_count_2", hit_count, 2);
        chk("data_5_after_wr", data_mem[5], 8'h5A);

        // Conflicting read: write-back then allocate.
        ack_delay = 2;
        push_ram(1'b1, 13'h0005, 8'h5A);
        push_ram(1'b0, 13'h0405, 8'h00);
        do_req(1'b0, 13'h0405, 8'h00, 8'h77, 9, "rd_dirty_miss_405");
        chk("miss_count_2", miss_count, 2);
        chk("ram_5_written_back", ram_mem[13'h0005], 8'h5A);
        chk("tag_5_now_1", tag_mem[5], 1);

        // Write miss to the top line with slow RAM.
        ack_delay = 4;
        push_ram(1'b0, 13'h1FFF, 8'h00);
        do_req(1'b1, 13'h1FFF, 8'h3C, 8'h00, 8, "wr_miss_1fff");
        chk("tag_1023", tag_mem[1023], 7);
        chk("data_1023", data_mem[1023], 8'h3C);
        chk("miss_count_3", miss_count, 3);

        // Zero-wait RAM on a dirty eviction of that line.
        ack_delay = 0;
        push_ram(1'b1, 13'h1FFF, 8'h3C);
        push_ram(1'b0, 13'h0FFF, 8'h00);
        do_req(1'b0, 13'h0FFF, 8'h00, 8'h22, 5, "rd_zero_wait_fff");
        chk("ram_1fff_written_back", ram_mem[13'h1FFF], 8'h3C);
        chk("miss_count_4", miss_count, 4);

        // Line now clean: re-reading 0x1FFF is a plain allocate.
        push_ram(1'b0, 13'h1FFF, 8'h00);
        do_req(1'b0, 13'h1FFF, 8'h00, 8'h3C, 4, "rd_clean_miss_1fff");
        chk("counts_5", {hit_count, miss_count}, {16'd2, 16'd5});

        // Reset while ALLOCATE is waiting for RAM: request dropped.
        ack_delay = 20;
        @(negedge globalclock);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 13'h0005;
        @(posedge globalclock);
        #1 cpu_req = 1'b0;
        @(negedge globalclock);
        @(negedge globalclock);
        chk("alloc_wait_req", ram_req, 1);
        @(negedge globalclock);
        reset = 1'b1;
        @(posedge globalclock);
        @(negedge globalclock);
        chk("rst_mid_ram_req", ram_req, 0);
        chk("rst_mid_ready", cpu_ready, 1);
        chk("rst_mid_counts", {hit_count, miss_count}, 0);
        reset = 1'b0;
        repeat (6) @(negedge globalclock);
        chk("rst_mid_no_done", cpu_done, 0);

        // Line state was cleared, so the same address misses (clean).
        ack_delay = 1;
        push_ram(1'b0, 13'h0005, 8'h00);
        do_req(1'b0, 13'h0005, 8'h00, 8'h5A, 5, "rd_after_reset_5");
        chk("post_rst_counts", {hit_count, miss_count}, {16'd0, 16'd1});

        repeat (3) @(negedge globalclock);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("ram_q_drained", ram_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/direct_cache_controller.md
# direct_cache_controller

Sequencing FSM for the direct-mapped cache: accepts one CPU load/store at a time, drives the existing tag memory and the cache data memory, and runs write-back/allocate transactions on the RAM interface. It owns the per-line valid and dirty state, which the tag memory does not store. The policy is write-back, write-allocate, one data word per line.

## Interface
- INDEX_W, 10, line index width (1024 lines)
- TAG_W, 3, tag width; CPU/RAM address width = TAG_W+INDEX_W = 13
- DATA_W, 8, word/line width
- globalclock  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request strobe, sampled only when cpu_ready=1
- cpu_rw  in  1  1=write, 0=read
- cpu_addr  in  13  {tag, index}
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  high only in IDLE
- cpu_done  out  1  one-cycle completion pulse, registered
- cpu_rdata  out  DATA_W  load result, registered, valid with cpu_done and held until next completion
- tag_wr_en / tag_addr / tag_in  out  1 / INDEX_W / TAG_W  tag memory write port
- tag_out  in  TAG_W  tag memory combinational read at tag_addr
- data_wr_en / data_addr / data_in  out  1 / INDEX_W / DATA_W  data memory port
- data_out  in  DATA_W  data memory combinational read at data_addr
- ram_req / ram_we / ram_addr / ram_wdata  out  1 / 1 / 13 / DATA_W  RAM request
- ram_ack  in  1  one-cycle completion from RAM
- ram_rdata  in  DATA_W  fill data, valid with ram_ack
- hit_count, miss_count  out  16  saturating event counters

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE: cpu_ready=1. On cpu_req, latch addr/rw/wdata, go to COMPARE. No request is accepted in any other state.
- COMPARE: tag_addr=data_addr=latched index. hit = valid[idx] && tag_out==latched tag.
  - Read hit: cpu_rdata<=data_out, cpu_done, hit_count++, go to IDLE.
  - Write hit: data_wr_en=1, data_in=wdata, dirty[idx]<=1, cpu_done, hit_count++, go to IDLE.
  - Miss: miss_count++. Latch victim tag_out and data_out. Go to WRITEBACK if valid&&dirty, otherwise to ALLOCATE.
- WRITEBACK: ram_req=1, ram_we=1, ram_addr={victim tag, idx}, ram_wdata=victim data. Go to ALLOCATE on ram_ack.
- ALLOCATE: ram_req=1, ram_we=0, ram_addr=latched addr. On ram_ack, latch ram_rdata and go to UPDATE.
- UPDATE: tag_wr_en=1, tag_in=latched tag, data_wr_en=1, valid[idx]<=1.
  - Read miss: data_in=fill data, dirty<=0, cpu_rdata<=fill.
  - Write miss: data_in=wdata, dirty<=1.
  - In both cases: cpu_done, go to IDLE.
- Outputs ram_req/ram_we/ram_addr/ram_wdata, tag_wr_en and data_wr_en are Moore outputs of state and latched registers.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: state=IDLE, cpu_ready=1, cpu_done=0, cpu_rdata=0, ram_req=0, ram_we=0, all write enables 0, counters 0, all valid/dirty bits 0.
- Request accepted at edge T. COMPARE at T+1. A hit gives cpu_done at T+2.
- Clean miss: ALLOCATE from T+2. If ram_ack arrives in cycle A, UPDATE is A+1 and cpu_done is A+2.
- Dirty miss: WRITEBACK from T+2. If its ack is in W, ALLOCATE begins at W+1.
- RAM handshake: ram_req is held with stable address/data until ram_ack. Each ram_ack consumes exactly one request. A back-to-back request (WRITEBACK to ALLOCATE) keeps ram_req high but changes ram_we/ram_addr at W+1. ram_ack while ram_req=0 is ignored.
- ram_ack in the first cycle of WRITEBACK/ALLOCATE is legal (zero-wait RAM).
- Reset in any state takes effect at that edge: FSM to IDLE, ram_req=0 the next cycle, line state cleared, the pending CPU request is dropped with no cpu_done.
- Same-index reuse: a request following an UPDATE sees the new tag and line state, because UPDATE writes land before the next COMPARE.

## Structure
- Shared package cache_pkg: state enum, INDEX_W/TAG_W/DATA_W constants, address split helpers (tag = addr[12:10], index = addr[9:0]).
- Sub-module cache_line_status: 1024×{valid,dirty} register array, sync reset to 0, combinational read, single write port. The FSM, latches and counters stay in the top module.

## Test plan
- Read 0x0005 after reset: miss, ALLOCATE with ram_addr=0x0005, ram_rdata=0xA5. Then cpu_rdata=0xA5, miss_count=1, tag written as 0.
- Repeat read 0x0005: hit, cpu_done at T+2, no ram_req, cpu_rdata=0xA5, hit_count=1.
- Write 0x5A to 0x0005 (hit). Then read 0x0405 (same index, tag 1): WRITEBACK with ram_addr=0x0005 and ram_wdata=0x5A, then ALLOCATE with ram_addr=0x0405.
- Write miss to 0x1FFF with data 0x3C, RAM ack after 4 cycles. Expect dirty[1023]=1 and tag_in=7. A later eviction of that line writes back 0x3C to 0x1FFF.
- Reset asserted during ALLOCATE wait: ram_req low next cycle, no cpu_done, and a subsequent read of the same address misses.
- Zero-wait RAM (ack on the first request cycle) on a dirty miss: two acks consumed, completion in minimum cycles, no duplicate requests.
